// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, a direct-mapped one-word-per-line
// instruction cache with combinational lookup, a single outstanding miss
// request to instruction memory, and stall / branch-redirect handling.
module instruction_fetch_unit #(
  parameter int unsigned LINES    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] next_pc,
  output logic        hit,
  output logic        valid
);

  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX;

  typedef enum logic {
    LOOKUP = 1'b0,
    MISS   = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instruction_reg, instruction_next;
  logic [31:0] next_pc_reg, next_pc_next;
  logic        hit_reg, hit_next;
  logic        valid_reg, valid_next;
  logic        mem_req_reg, mem_req_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic        redir_pend_reg, redir_pend_next;
  logic [31:0] redir_pc_reg, redir_pc_next;

  // Cache storage: valid bits are reset, tag and data arrays are not.
  logic [LINES-1:0] line_valid_reg;
  logic [TAG_W-1:0] line_tag_reg  [LINES];
  logic [31:0]      line_data_reg [LINES];

  // Lookup on the current PC; pc[1:0] never participates.
  logic [IDX-1:0]   pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             lookup_hit;
  logic [31:0]      pc_plus4;

  assign pc_idx     = pc_reg[2+IDX-1:2];
  assign pc_tag     = pc_reg[31:2+IDX];
  assign lookup_hit = line_valid_reg[pc_idx] && (line_tag_reg[pc_idx] == pc_tag);
  assign pc_plus4   = pc_reg + 32'd4;

  // Fill always targets the address of the outstanding request.
  logic             fill_en;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [LINES-1:0] fill_sel;

  assign fill_idx = mem_addr_reg[2+IDX-1:2];
  assign fill_tag = mem_addr_reg[31:2+IDX];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_fill_sel
      assign fill_sel[gi] = fill_en && (fill_idx == IDX'(gi));
    end
  endgenerate

  // Line valid bits: cleared by reset, set by a fill (never cleared otherwise).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_valid_reg <= '0;
    end else begin
      line_valid_reg <= line_valid_reg | fill_sel;
    end
  end

  // Tag and data write on fill; a fill simply evicts the previous occupant.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_tag_reg[fill_idx]  <= fill_tag;
      line_data_reg[fill_idx] <= mem_rdata;
    end
  end

  // State, PC and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= LOOKUP;
      pc_reg          <= RESET_PC;
      instruction_reg <= 32'h0;
      next_pc_reg     <= 32'h0;
      hit_reg         <= 1'b0;
      valid_reg       <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= 32'h0;
      redir_pend_reg  <= 1'b0;
      redir_pc_reg    <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instruction_reg <= instruction_next;
      next_pc_reg     <= next_pc_next;
      hit_reg         <= hit_next;
      valid_reg       <= valid_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      redir_pend_reg  <= redir_pend_next;
      redir_pc_reg    <= redir_pc_next;
    end
  end

  // Next-state and output decisions for the LOOKUP / MISS controller.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instruction_next = instruction_reg;
    next_pc_next     = next_pc_reg;
    hit_next         = hit_reg;
    valid_next       = valid_reg;
    mem_req_next     = mem_req_reg;
    mem_addr_next    = mem_addr_reg;
    redir_pend_next  = redir_pend_reg;
    redir_pc_next    = redir_pc_reg;
    fill_en          = 1'b0;

    unique case (state_reg)
      LOOKUP: begin
        if (branch_taken) begin
          // Redirect wins over stall; emit a bubble.
          pc_next    = branch_target;
          valid_next = 1'b0;
          hit_next   = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else if (lookup_hit) begin
          instruction_next = line_data_reg[pc_idx];
          next_pc_next     = pc_plus4;
          hit_next         = 1'b1;
          valid_next       = 1'b1;
          pc_next          = pc_plus4;
        end else begin
          valid_next    = 1'b0;
          hit_next      = 1'b0;
          mem_req_next  = 1'b1;
          mem_addr_next = pc_reg;
          state_next    = MISS;
        end
      end

      MISS: begin
        if (mem_ready) begin
          // The fill happens regardless of stall or redirect.
          fill_en      = 1'b1;
          mem_req_next = 1'b0;
          state_next   = LOOKUP;
          if (branch_taken || redir_pend_reg) begin
            pc_next         = branch_taken ? branch_target : redir_pc_reg;
            valid_next      = 1'b0;
            hit_next        = 1'b0;
            redir_pend_next = 1'b0;
          end else if (!stall) begin
            instruction_next = mem_rdata;
            next_pc_next     = pc_plus4;
            hit_next         = 1'b0;
            valid_next       = 1'b1;
            pc_next          = pc_plus4;
          end else begin
            // Word is in the cache now; it is delivered later as a hit.
            valid_next = 1'b0;
            hit_next   = 1'b0;
          end
        end else if (branch_taken) begin
          // Request cannot be aborted; remember the latest redirect.
          redir_pend_next = 1'b1;
          redir_pc_next   = branch_target;
        end
      end

      default: begin
        state_next = LOOKUP;
      end
    endcase
  end

  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign instruction = instruction_reg;
  assign next_pc     = next_pc_reg;
  assign hit         = hit_reg;
  assign valid       = valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a cycle-exact vector table
// plus hand-written multi-cycle sequences, with a scoreboard of expected
// deliveries (pc, hit) compared whenever the DUT presents a fresh instruction.
module tb_instruction_fetch_unit;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instruction;
  logic [31:0] next_pc;
  logic        hit;
  logic        valid;

  always #5 clock = ~clock;

  instruction_fetch_unit #(
    .LINES   (8),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .next_pc      (next_pc),
    .hit          (hit),
    .valid        (valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
  } exp_t;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        e_valid;
    logic        e_hit;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  int unsigned lat = 0;
  int unsigned mem_cnt = 0;
  logic        delivered = 1'b0;
  logic [31:0] prev_instr;
  logic [31:0] prev_npc;
  logic        prev_valid;
  logic        prev_hit;
  vec_t        vecs[30];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
  endfunction

  function automatic vec_t mkv(input logic st, input logic br, input logic [31:0] tgt,
                               input logic ev, input logic eh, input logic er,
                               input logic [31:0] ea, input logic [31:0] ep);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt;
    v.e_valid = ev; v.e_hit = eh; v.e_req = er; v.e_addr = ea; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mke(input logic [31:0] pc, input logic h);
    exp_t e;
    e.pc = pc;
    e.hit = h;
    return e;
  endfunction

  // One clock: memory responder + input drive at negedge, checks at posedge+1.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    exp_t e;
    @(negedge clock);
    if (mem_ready) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_req) begin
      if (mem_cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    prev_instr = instruction;
    prev_npc   = next_pc;
    prev_valid = valid;
    prev_hit   = hit;
    @(posedge clock);
    #1;
    delivered = 1'b0;
    if (st && !br) begin
      chk("stall_hold_instr", instruction, prev_instr);
      chk("stall_hold_npc", next_pc, prev_npc);
      chk("stall_hold_valid", {31'h0, valid}, {31'h0, prev_valid});
      chk("stall_hold_hit", {31'h0, hit}, {31'h0, prev_hit});
    end else if (valid) begin
      delivered = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h, expected no delivery", next_pc - 32'd4);
      end else begin
        e = sb.pop_front();
        chk("deliver_instr", instruction, mem_word(e.pc));
        chk("deliver_npc", next_pc, e.pc + 32'd4);
        chk("deliver_hit", {31'h0, hit}, {31'h0, e.hit});
        $display("deliver pc=%h instr=%h next_pc=%h hit=%0d", e.pc, instruction, next_pc, hit);
      end
    end else begin
      chk("bubble_hit", {31'h0, hit}, 32'h0);
      chk("bubble_hold_instr", instruction, prev_instr);
      chk("bubble_hold_npc", next_pc, prev_npc);
    end
  endtask

  task automatic wait_delivery(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      step(N, N, 32'h0);
      if (delivered) break;
    end
    chk(name, {31'h0, delivered}, 32'h1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Cycle-exact table, memory answers one cycle after the request (lat=0).
    vecs[0]  = mkv(N, N, 32'h00, N, N, Y, 32'h00, 32'h00);
    vecs[1]  = mkv(N, N, 32'h00, Y, N, N, 32'h00, 32'h00);
    vecs[2]  = mkv(N, N, 32'h00, N, N, Y, 32'h04, 32'h00);
    vecs[3]  = mkv(N, N, 32'h00, Y, N, N, 32'h04, 32'h04);
    vecs[4]  = mkv(N, N, 32'h00, N, N, Y, 32'h08, 32'h00);
    vecs[5]  = mkv(N, N, 32'h00, Y, N, N, 32'h08, 32'h08);
    vecs[6]  = mkv(N, Y, 32'h00, N, N, N, 32'h08, 32'h00);
    vecs[7]  = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h00);
    vecs[8]  = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h04);
    vecs[9]  = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h08);
    vecs[10] = mkv(N, Y, 32'h00, N, N, N, 32'h08, 32'h00);
    vecs[11] = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h00);
    vecs[12] = mkv(Y, N, 32'h00, Y, Y, N, 32'h08, 32'h00);
    vecs[13] = mkv(Y, N, 32'h00, Y, Y, N, 32'h08, 32'h00);
    vecs[14] = mkv(Y, N, 32'h00, Y, Y, N, 32'h08, 32'h00);
    vecs[15] = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h04);
    vecs[16] = mkv(N, N, 32'h00, Y, Y, N, 32'h08, 32'h08);
    vecs[17] = mkv(N, N, 32'h00, N, N, Y, 32'h0C, 32'h00);
    vecs[18] = mkv(Y, N, 32'h00, N, N, N, 32'h0C, 32'h00);
    vecs[19] = mkv(Y, N, 32'h00, N, N, N, 32'h0C, 32'h00);
    vecs[20] = mkv(N, N, 32'h00, Y, Y, N, 32'h0C, 32'h0C);
    vecs[21] = mkv(N, N, 32'h00, N, N, Y, 32'h10, 32'h00);
    vecs[22] = mkv(N, Y, 32'h40, N, N, N, 32'h10, 32'h00);
    vecs[23] = mkv(N, N, 32'h00, N, N, Y, 32'h40, 32'h00);
    vecs[24] = mkv(N, N, 32'h00, Y, N, N, 32'h40, 32'h40);
    vecs[25] = mkv(N, Y, 32'h10, N, N, N, 32'h40, 32'h00);
    vecs[26] = mkv(N, N, 32'h00, Y, Y, N, 32'h40, 32'h10);
    vecs[27] = mkv(N, Y, 32'h00, N, N, N, 32'h40, 32'h00);
    vecs[28] = mkv(N, N, 32'h00, N, N, Y, 32'h00, 32'h00);
    vecs[29] = mkv(N, N, 32'h00, Y, N, N, 32'h00, 32'h00);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("reset_instr", instruction, 32'h0);
    chk("reset_npc", next_pc, 32'h0);
    chk("reset_hit", {31'h0, hit}, 32'h0);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_req", {31'h0, mem_req}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    release_reset();

    lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (vecs[i].e_valid && !vecs[i].st) sb.push_back(mke(vecs[i].e_pc, vecs[i].e_hit));
      step(vecs[i].st, vecs[i].br, vecs[i].tgt);
      chk($sformatf("row%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("row%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].e_hit});
      chk($sformatf("row%0d_req", i), {31'h0, mem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("row%0d_addr", i), mem_addr, vecs[i].e_addr);
    end
    chk("table_sb_empty", sb.size(), 32'h0);

    // Fresh reset, memory ready after 3 waiting cycles.
    reset_n = 1'b0;
    mem_ready = 1'b0;
    mem_cnt = 0;
    #1;
    release_reset();
    lat = 3;
    sb.push_back(mke(32'h0, N));
    begin
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        step(N, N, 32'h0);
        n++;
        if (delivered) break;
        chk("missA_req", {31'h0, mem_req}, 32'h1);
        chk("missA_addr", mem_addr, 32'h0);
      end
      chk("missA_latency", n, 32'd5);
    end
    step(N, N, 32'h0);
    chk("missA_next_req", {31'h0, mem_req}, 32'h1);
    chk("missA_next_addr", mem_addr, 32'h4);

    // Redirects during MISS for pc=4: request completes, latest target wins.
    step(N, Y, 32'h40);
    chk("redir_req1", {31'h0, mem_req}, 32'h1);
    chk("redir_addr1", mem_addr, 32'h4);
    step(N, Y, 32'h80);
    chk("redir_req2", {31'h0, mem_req}, 32'h1);
    chk("redir_addr2", mem_addr, 32'h4);
    step(N, N, 32'h0);
    chk("redir_req3", {31'h0, mem_req}, 32'h1);
    step(N, N, 32'h0);
    chk("redir_done_req", {31'h0, mem_req}, 32'h0);
    chk("redir_done_valid", {31'h0, valid}, 32'h0);
    step(N, N, 32'h0);
    chk("redir_new_req", {31'h0, mem_req}, 32'h1);
    chk("redir_new_addr", mem_addr, 32'h80);
    sb.push_back(mke(32'h80, N));
    wait_delivery(20, "redir_wait_0x80");
    step(N, Y, 32'h4);
    sb.push_back(mke(32'h4, Y));
    step(N, N, 32'h0);
    chk("redir_fill_hit_req", {31'h0, mem_req}, 32'h0);
    chk("redir_fill_delivered", {31'h0, delivered}, 32'h1);

    // PC wrap-around at the top of the address space.
    step(N, Y, 32'hFFFF_FFFC);
    sb.push_back(mke(32'hFFFF_FFFC, N));
    wait_delivery(20, "wrap_wait");
    step(N, N, 32'h0);
    chk("wrap_next_req", {31'h0, mem_req}, 32'h1);
    chk("wrap_next_addr", mem_addr, 32'h0);

    // Asynchronous reset in the middle of a miss, then a stray late ready.
    step(N, N, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_miss_req", {31'h0, mem_req}, 32'h0);
    chk("rst_miss_valid", {31'h0, valid}, 32'h0);
    chk("rst_miss_instr", instruction, 32'h0);
    mem_cnt = 0;
    release_reset();
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0;
    branch_taken = 1'b0;
    @(posedge clock);
    #1;
    chk("late_ready_valid", {31'h0, valid}, 32'h0);
    chk("late_ready_req", {31'h0, mem_req}, 32'h1);
    chk("late_ready_addr", mem_addr, 32'h0);
    @(negedge clock);
    mem_ready = 1'b0;
    mem_cnt = 0;
    sb.push_back(mke(32'h0, N));
    wait_delivery(20, "post_reset_wait");

    chk("final_sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that produces the `instruction`, `next_pc` and `hit` values consumed by the IF/ID pipeline register in the MIPS core. It holds the program counter and looks each PC up in a small direct-mapped instruction cache. On a miss it fetches the word from instruction memory over a req/ready handshake and refills the cache. It also obeys stall and branch-redirect requests from downstream.

## Interface
Parameters:
- `LINES`, 8: cache lines, one 32-bit word each; power of two, ≥2; `IDX = log2(LINES)`.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  IF/ID cannot accept; hold outputs and PC.
- `branch_taken`  in  1  redirect request from decode/execute.
- `branch_target`  in  32  redirect PC; valid when `branch_taken`=1.
- `mem_req`  out  1  instruction-memory read request.
- `mem_addr`  out  32  word address of the request (equals PC).
- `mem_ready`  in  1  memory returns data this cycle.
- `mem_rdata`  in  32  returned instruction word.
- `instruction`  out  32  fetched instruction to IF/ID.
- `next_pc`  out  32  PC+4 of the delivered instruction.
- `hit`  out  1  1 if the delivered instruction came from the cache.
- `valid`  out  1  outputs carry a real instruction; 0 means bubble.

## Operation
- Cache: `LINES` entries of {valid bit, tag = pc[31:2+IDX], data}. Index = pc[2+IDX-1:2]. Lookup is combinational on the internal PC. pc[1:0] is ignored.
- FSM states:
  - LOOKUP (reset state):
    - `branch_taken`=1 (overrides `stall`): pc←branch_target, valid←0, stay.
    - else `stall`=1: hold pc and all outputs.
    - else hit: instruction←line data, next_pc←pc+4, hit←1, valid←1, pc←pc+4.
    - else miss: valid←0, mem_req←1, mem_addr←pc, go to MISS.
  - MISS: `mem_req` stays 1 and `mem_addr` stays stable until `mem_ready`=1. The request is never aborted.
    - `branch_taken` in MISS: store redir_pc←branch_target and set redir_pend. A later redirect overwrites an earlier one.
    - On `mem_ready`=1: write the line (valid←1, tag, mem_rdata), drop mem_req, return to LOOKUP, and act as follows:
      - redirect pending, or `branch_taken` in the same cycle (same-cycle target wins): pc←target, valid←0, clear redir_pend.
      - else `stall`=0: instruction←mem_rdata, next_pc←pc+4, hit←0, valid←1, pc←pc+4.
      - else (stall): pc holds, valid←0. The word is delivered later from the cache with hit=1.
- A fill overwrites the previous occupant of its index (conflict eviction). There is no write-back.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert, sync release): pc=RESET_PC; all cache valid bits 0; state LOOKUP; instruction=0, next_pc=0, hit=0, valid=0, mem_req=0, mem_addr=0; redir_pend=0.
- Reset asserted mid-MISS drops `mem_req` immediately. Any late `mem_ready` after release is ignored in LOOKUP.
- Hit: outputs registered one edge after the lookup. Throughput is one instruction per cycle on consecutive hits.
- Miss: `mem_req` rises at the edge the miss is detected. Data reaches the outputs at the edge where `mem_ready` is sampled high. Penalty is 1 + (cycles waiting for ready).
- `stall` affects only output/PC advance; it never blocks a cache fill.
- `valid`=0 outputs still hold their previous `instruction`/`next_pc` values. Only `valid` and `hit` change on bubbles; `hit`←0 whenever valid←0.

## Test plan
- Reset with RESET_PC=0, empty cache, memory ready after 3 cycles → mem_req=1, mem_addr=0. On ready: valid=1, hit=0, instruction=mem word@0, next_pc=4. The next lookup (pc=4) misses.
- Execute 0,4,8, then branch_taken with target 0 → valid=0 for one cycle, then 0,4,8 delivered on consecutive cycles with hit=1 and no mem_req.
- stall=1 for 3 cycles during a hit stream → instruction, next_pc and pc unchanged. Release resumes with the next sequential PC; no instruction is skipped or duplicated.
- branch_taken(target 0x40) during MISS for pc=0x10 → mem_req held to completion and line 0x10 filled, valid stays 0. The next request is mem_addr=0x40; 0x10's word is never delivered.
- LINES=8: fetch 0x00, then branch to 0x20 (same index) and back to 0x00 → each access misses; the second access to 0x00 shows hit=0 and mem_req=1.
- mem_ready coincident with stall=1 → valid=0, pc held. After stall drops, the same word is delivered with hit=1 and no new mem_req.
